// File: rtl/inst_mem_loader.sv
// Boot loader for instruction memory: assembles a little-endian byte stream into
// 32-bit words, writes them from address 0, then verifies a trailing checksum word.
module inst_mem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              pc_en,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LOAD, CHK, RUN, ERR} state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_WORDS);

  state_t            state, state_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [23:0]       asm_q, asm_n;
  logic [ADDR_W:0]   word_cnt, word_cnt_n;
  logic [ADDR_W:0]   len_q, len_n;
  logic [31:0]       sum, sum_n;
  logic              mem_we_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_wdata_n;
  logic              rx_ready_n;
  logic              acc;
  logic [31:0]       full;

  assign acc  = rx_valid & rx_ready;
  assign full = {rx_data, asm_q};

  always_comb begin
    state_n     = state;
    byte_cnt_n  = byte_cnt;
    asm_n       = asm_q;
    word_cnt_n  = word_cnt;
    len_n       = len_q;
    sum_n       = sum;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;

    if (acc) begin
      byte_cnt_n = byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    asm_n[7:0]   = rx_data;
        2'd1:    asm_n[15:8]  = rx_data;
        2'd2:    asm_n[23:16] = rx_data;
        default: ;
      endcase
    end

    case (state)
      IDLE, ERR: begin
        if (start) begin
          if (len >= 1 && len <= MAX_LEN) begin
            state_n    = LOAD;
            word_cnt_n = '0;
            sum_n      = '0;
            byte_cnt_n = '0;
            len_n      = len;
          end else begin
            state_n = ERR;
          end
        end
      end
      LOAD: begin
        // rx_ready is held low during the last word's write, so CHK starts clean
        if (mem_we && word_cnt == len_q) state_n = CHK;
        if (acc && byte_cnt == 2'd3) begin
          mem_we_n    = 1'b1;
          mem_addr_n  = word_cnt[ADDR_W-1:0];
          mem_wdata_n = full;
          sum_n       = sum + full;
          word_cnt_n  = word_cnt + 1'b1;
        end
      end
      CHK: begin
        if (acc && byte_cnt == 2'd3) state_n = (full == sum) ? RUN : ERR;
      end
      RUN:     ;
      default: state_n = IDLE;
    endcase

    rx_ready_n = (state_n == CHK) ||
                 (state_n == LOAD && !(mem_we_n && word_cnt_n == len_n));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      asm_q     <= '0;
      word_cnt  <= '0;
      len_q     <= '0;
      sum       <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      pc_en     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      byte_cnt  <= byte_cnt_n;
      asm_q     <= asm_n;
      word_cnt  <= word_cnt_n;
      len_q     <= len_n;
      sum       <= sum_n;
      rx_ready  <= rx_ready_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      busy      <= (state_n == LOAD) || (state_n == CHK);
      pc_en     <= (state_n == RUN);
      err       <= (state_n == ERR);
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed + randomized bench for inst_mem_loader; expected memory image and
// checksum come from a word-list model summed with plain arithmetic.
module tb_inst_mem_loader;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [10:0] len = '0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready, mem_we, busy, pc_en, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;

  int checks = 0, errors = 0;
  logic [31:0] wq[$];
  int          wa_q[$];
  logic [31:0] wd_q[$];
  int          we_cnt = 0, b2b = 0, rdy_cnt = 0;
  logic        prev_we = 1'b0;

  inst_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .pc_en(pc_en), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(mem_wdata);
      we_cnt <= we_cnt + 1;
      if (prev_we) b2b <= b2b + 1;
    end
    prev_we <= mem_we;
    if (rx_ready) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_sum();
    logic [31:0] s = '0;
    foreach (wq[i]) s = s + wq[i];
    return s;
  endfunction

  task automatic rand_words(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom());
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic pulse_start(input int l);
    start = 1'b1; len = 11'(l);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok = 1'b0;
    if (gaps && $urandom_range(1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
    #1 rx_data = b; rx_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rx_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] v, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8], gaps);
  endtask

  task automatic wait_done(input string tag);
    bit done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (pc_en || err) begin done = 1'b1; break; end
    end
    chk({tag, "_timeout"}, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  // Full load of wq followed by chkw; start_at >= 0 pulses start mid-load.
  task automatic load(input string tag, input logic [31:0] chkw, input bit gaps, input int start_at);
    int   l    = wq.size();
    int   base = we_cnt;
    logic good = (chkw == ref_sum());
    pulse_start(l);
    chk({tag, "_busy_on_entry"}, 32'(busy), 32'd1);
    chk({tag, "_err_clr"}, 32'(err), 32'd0);
    for (int i = 0; i < l; i++) begin
      if (i == start_at) pulse_start(3);
      send_word(wq[i], gaps);
    end
    send_word(chkw, gaps);
    wait_done(tag);
    chk({tag, "_we_count"}, 32'(we_cnt - base), 32'(l));
    for (int i = 0; i < l; i++) begin
      if (base + i < wa_q.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(wa_q[base+i]), 32'(i));
        chk($sformatf("%s_data%0d", tag, i), wd_q[base+i], wq[i]);
      end
    end
    chk({tag, "_pc_en"}, 32'(pc_en), 32'(good));
    chk({tag, "_err"}, 32'(err), 32'(!good));
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_no_b2b_we"}, 32'(b2b), 32'd0);
  endtask

  initial begin
    int base, base_rdy;
    do_reset();
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // known two-word program and its checksum
    wq = '{32'h0000_0013, 32'h0010_0093};
    load("t1", 32'h0010_00A6, 1'b0, -1);

    // corrupted checksum, then recover from ERR with a good stream
    do_reset();
    load("t2bad", 32'h0010_00A7, 1'b0, -1);
    load("t2good", 32'h0010_00A6, 1'b0, -1);

    // illegal lengths
    do_reset();
    base = we_cnt; base_rdy = rdy_cnt;
    pulse_start(0);
    repeat (3) @(posedge clk); #1;
    chk("t3_len0_err", 32'(err), 32'd1);
    chk("t3_len0_busy", 32'(busy), 32'd0);
    pulse_start(1025);
    repeat (3) @(posedge clk); #1;
    chk("t3_lenmax1_err", 32'(err), 32'd1);
    chk("t3_rdy_never", 32'(rdy_cnt - base_rdy), 32'd0);
    chk("t3_we_never", 32'(we_cnt - base), 32'd0);

    // 16 words back-to-back and with random valid gaps
    rand_words(16);
    do_reset();
    load("t4b2b", ref_sum(), 1'b0, -1);
    do_reset();
    load("t4gap", ref_sum(), 1'b1, -1);

    // reset in the middle of a load, then reload
    rand_words(4);
    do_reset();
    pulse_start(4);
    for (int i = 0; i < 6; i++) send_byte(wq[i/4][8*(i%4) +: 8], 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_rx_ready", 32'(rx_ready), 32'd0);
    chk("t5_mem_we", 32'(mem_we), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_pc_en", 32'(pc_en), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;
    load("t5reload", ref_sum(), 1'b0, -1);

    // start during LOAD and in RUN is ignored
    rand_words(8);
    do_reset();
    load("t6", ref_sum(), 1'b1, 5);
    base = we_cnt;
    pulse_start(4);
    repeat (5) @(posedge clk); #1;
    chk("t6_run_pc_en", 32'(pc_en), 32'd1);
    chk("t6_run_busy", 32'(busy), 32'd0);
    chk("t6_run_no_we", 32'(we_cnt - base), 32'd0);

    // randomized lengths and checksum corruption
    for (int k = 0; k < 6; k++) begin
      logic [31:0] c;
      rand_words($urandom_range(1, 20));
      c = ref_sum();
      if ($urandom_range(1) == 1) c = c ^ (32'd1 << $urandom_range(31));
      do_reset();
      load($sformatf("rnd%0d", k), c, 1'(k % 2), -1);
    end

    // largest legal program
    rand_words(1024);
    do_reset();
    load("max", ref_sum(), 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
